// File: rtl/if_prefetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, FIFO entry layout, filler opcode.
// No logic here, so no latency and no flow control.
package if_pkg;

  localparam int IF_ADDR_W = 9;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } if_state_t;

  // Entry width follows IF_ADDR_W; if_prefetch's ADDR_W is expected to match it.
  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [31:0]          inst;
  } if_entry_t;

endpackage

// File: rtl/if_prefetch_inst_fifo.sv
// Synchronous FIFO, DEPTH a power of two; a push is visible at the head from the following edge.
// No internal flow control: the caller never pushes when full or pops when empty; clear beats push.
module inst_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Fetch front end: one outstanding imem read, results queued in a prefetch FIFO; head registered, 1 instr/cycle.
// Requests are issued only when the FIFO will have room; decode stall holds the head; redirect flushes.
module if_prefetch
  import if_pkg::*;
#(
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   stall,
  output logic                   inst_valid,
  output logic [31:0]            inst,
  output logic [ADDR_W-1:0]      inst_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  if_state_t         state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] redir_pc;
  logic              push;
  logic              pop;
  logic [CW-1:0]     count_nxt;
  logic              space;
  if_entry_t         push_ent;
  if_entry_t         head_ent;

  assign redir_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pop       = inst_valid && !stall && !redirect;
  assign push      = (state == WAIT) && imem_ack && !redirect;
  // Occupancy after this edge decides whether a new request may go out.
  assign count_nxt = redirect ? '0 : fifo_count + CW'(push) - CW'(pop);
  assign space     = count_nxt < CW'(DEPTH);

  always_comb begin
    state_nxt    = state;
    addr_nxt     = imem_addr;
    fetch_pc_nxt = fetch_pc;
    if (redirect)  fetch_pc_nxt = redir_pc;
    else if (push) fetch_pc_nxt = fetch_pc + ADDR_W'(4);

    case (state)
      IDLE: begin
        if (space) begin
          state_nxt = WAIT;
          addr_nxt  = fetch_pc_nxt;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_nxt = imem_ack ? IDLE : DISCARD;
        end else if (imem_ack) begin
          if (space) addr_nxt  = fetch_pc_nxt;
          else       state_nxt = IDLE;
        end
      end
      DISCARD: begin
        // Old address stays on the bus until the stale response is swallowed.
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      imem_addr <= addr_nxt;
    end
  end

  assign imem_req = (state != IDLE);

  assign push_ent = '{pc: fetch_pc, inst: imem_rdata};

  inst_fifo #(
    .W     ($bits(if_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .clear    (redirect),
    .count    (fifo_count),
    .head     (head_ent)
  );

  assign inst_valid = (fifo_count != '0);
  assign inst       = head_ent.inst;
  assign inst_pc    = head_ent.pc;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed scenarios plus randomized memory latency, stall and redirect traffic.
// A transaction-level model (queue of expected entries, next fetch address) predicts every output.
module tb_if_prefetch;
  import if_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = INST_NOP;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [8:0]  inst_pc;
  logic [2:0]  fifo_count;

  logic        w_req;
  logic [8:0]  w_addr;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [8:0]  w_pc;
  logic [2:0]  w_cnt;
  logic        w_redirect = 1'b0;
  logic [8:0]  w_redirect_pc = '0;
  logic        w_stall = 1'b0;
  logic [31:0] w_rdata = INST_NOP;

  always #5 clk = ~clk;

  if_prefetch #(.ADDR_W(9), .DEPTH(DEPTH), .RESET_PC(9'h000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .fifo_count(fifo_count)
  );

  // Zero-wait memory wired straight to the request: checks address wrap from a high reset PC.
  if_prefetch #(.ADDR_W(9), .DEPTH(DEPTH), .RESET_PC(9'h1F8)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_rdata(w_rdata), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .stall(w_stall), .inst_valid(w_valid),
    .inst(w_inst), .inst_pc(w_pc), .fifo_count(w_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] word(input logic [8:0] a);
    return {14'h2A5A, ~a, a};
  endfunction

  // Reference model state
  if_entry_t  q[$];
  logic [8:0] m_pc;
  logic [8:0] m_addr;
  bit         m_req;
  bit         stale;
  // Memory stimulus state
  bit         pending;
  int         lat, wcnt;
  int         lat_lo = 0, lat_hi = 0;

  task automatic do_reset();
    reset = 1'b0;
    imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0; imem_rdata = INST_NOP;
    @(posedge clk); @(posedge clk); #1;
    q.delete();
    m_pc = 9'h000; m_addr = 9'h000; m_req = 0; stale = 0; pending = 0; wcnt = 0;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_count", fifo_count, 0);
    reset = 1'b1;
  endtask

  task automatic step(input bit redir, input logic [8:0] rpc, input bit stl);
    bit ack, kept, pop, m_new;
    int post;
    check("imem_req", imem_req, m_req);
    if (m_req) check("imem_addr", imem_addr, m_addr);
    check("inst_valid", inst_valid, q.size() != 0);
    check("fifo_count", fifo_count, q.size());
    if (q.size() != 0) begin
      check("inst", inst, q[0].inst);
      check("inst_pc", inst_pc, q[0].pc);
    end
    ack = 0;
    if (imem_req) begin
      if (!pending) begin
        lat  = $urandom_range(lat_hi, lat_lo);
        wcnt = 0;
      end
      ack = (wcnt == lat);
      wcnt++;
    end
    pending    = imem_req && !ack;
    imem_ack   = ack;
    imem_rdata = ack ? word(imem_addr) : INST_NOP;
    redirect   = redir;
    redirect_pc = rpc;
    stall      = stl;

    pop  = (q.size() != 0) && !stl && !redir;
    kept = ack && m_req && !stale && !redir;
    if (redir) begin
      q.delete();
      stale = m_req && !ack;
      m_pc  = {rpc[8:2], 2'b00};
    end else begin
      if (pop) void'(q.pop_front());
      if (kept) begin
        q.push_back('{pc: m_pc, inst: word(m_pc)});
        m_pc = m_pc + 9'd4;
      end
      if (ack) stale = 0;
    end
    post  = q.size();
    m_new = 0;
    if (!m_req)   m_new = (post < DEPTH);
    else if (ack) m_new = kept && (post < DEPTH);
    if (m_new) m_addr = m_pc;
    m_req = m_new || (m_req && !ack);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;

    // Cold start, zero-wait, no stall; wrap instance runs alongside.
    lat_lo = 0; lat_hi = 0;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step(0, 9'h000, 0);
      check("cold_req", imem_req, 1);
      check("cold_addr", imem_addr, 9'(4 * (k - 1)));
      if (k >= 2) begin
        check("cold_valid", inst_valid, 1);
        check("cold_pc", inst_pc, 9'(4 * (k - 2)));
      end
      if (k <= 3) check("wrap_addr", w_addr, 9'(9'h1F8 + 4 * (k - 1)));
      if (k >= 2 && k <= 4) check("wrap_pc", w_pc, 9'(9'h1F8 + 4 * (k - 2)));
    end

    // Stall fills the FIFO, then release drains and refetches from 16.
    do_reset();
    for (int k = 0; k < 10; k++) step(0, 9'h000, 1);
    check("stall_req", imem_req, 0);
    check("stall_count", fifo_count, 4);
    check("stall_head", inst_pc, 9'h000);
    step(0, 9'h000, 0);
    check("refetch_req", imem_req, 1);
    check("refetch_addr", imem_addr, 9'd16);
    check("drain_pc", inst_pc, 9'h004);
    for (int k = 0; k < 4; k++) step(0, 9'h000, 0);

    // Redirect coinciding with ack and pop: nothing pushed or popped, next fetch at target.
    check("pre_redir_valid", inst_valid, 1);
    step(1, 9'h083, 0);
    check("redir_count", fifo_count, 0);
    check("redir_valid", inst_valid, 0);
    check("redir_req", imem_req, 0);
    step(0, 9'h000, 0);
    check("redir_new_req", imem_req, 1);
    check("redir_new_addr", imem_addr, 9'h080);
    for (int k = 0; k < 3; k++) step(0, 9'h000, 0);

    // Redirect while a slow read is outstanding: the old word is dropped.
    lat_lo = 2; lat_hi = 2;
    do_reset();
    step(0, 9'h000, 0);
    step(1, 9'h041, 0);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (!imem_req) found = 1;
      else step(0, 9'h000, 0);
    end
    check("discard_end", found, 1);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (imem_req) found = 1;
      else step(0, 9'h000, 0);
    end
    check("discard_refetch", found, 1);
    check("discard_addr", imem_addr, 9'h040);
    check("discard_count", fifo_count, 0);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (inst_valid) found = 1;
      else step(0, 9'h000, 0);
    end
    check("discard_first", found, 1);
    check("discard_first_pc", inst_pc, 9'h040);

    // Three-cycle latency: one instruction every three cycles; then reset mid-WAIT.
    do_reset();
    for (int k = 0; k < 10; k++) step(0, 9'h000, 0);
    check("slow_valid", inst_valid, 1);
    check("slow_pc", inst_pc, 9'h008);
    check("slow_inst", inst, word(9'h008));
    check("slow_req", imem_req, 1);
    reset = 1'b0;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_addr", imem_addr, 0);
    check("arst_valid", inst_valid, 0);
    check("arst_inst", inst, 0);
    check("arst_pc", inst_pc, 0);
    check("arst_count", fifo_count, 0);

    // Randomized traffic against the model.
    lat_lo = 0; lat_hi = 3;
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 19) == 0), 9'($urandom_range(0, 511)), ($urandom_range(0, 9) < 3));
    end
    lat_lo = 0; lat_hi = 0;
    for (int k = 0; k < 40; k++) step(0, 9'h000, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction-fetch front end that sits directly upstream of the `riscv` datapath. It issues word reads to instruction memory over a req/ack handshake and holds fetched instructions in a small prefetch FIFO. It presents one instruction per cycle to the decode stage. On a branch or jump redirect it flushes stale entries and discards any in-flight response.

## Interface
- `ADDR_W`, 9: byte-address width of instruction memory.
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `RESET_PC`, 0: first fetch address after reset; word-aligned.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request; held high until acked.
- `imem_addr`  out  ADDR_W  byte address, bits [1:0] always 0; stable while `imem_req`=1.
- `imem_ack`  in  1  response valid; may be asserted in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack`=1.
- `redirect`  in  1  one-cycle pulse from the datapath on a taken branch, JAL or JALR.
- `redirect_pc`  in  ADDR_W  new fetch address; bits [1:0] ignored and forced to 0.
- `stall`  in  1  decode cannot accept; suppresses pop.
- `inst_valid`  out  1  FIFO head is valid.
- `inst`  out  32  FIFO head instruction.
- `inst_pc`  out  ADDR_W  address of `inst`.
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, data will be kept.
  - DISCARD: request outstanding, data will be dropped.
- Pop condition: `inst_valid && !stall && !redirect`.
- Push condition: `imem_ack` in WAIT with no `redirect` in the same cycle. The entry pushed is {`fetch_pc`, `imem_rdata`}, then `fetch_pc` += 4.
- Space check: a request may be issued only when `count + push - pop < DEPTH`. One outstanding request maximum, so overflow is impossible.
- IDLE → WAIT: when there is space; `imem_req`=1 and `imem_addr`=`fetch_pc` are registered on the transition.
- WAIT, on ack:
  - If space remains after this cycle, stay in WAIT with `imem_addr`=`fetch_pc`+4 (back-to-back).
  - Otherwise go to IDLE with `imem_req`=0.
- Redirect, any state:
  - The FIFO is cleared at the next edge (`count`=0, pointers reset).
  - `fetch_pc` ← `redirect_pc` with bits [1:0] forced to 00.
  - A pop in the same cycle is suppressed.
- Redirect in WAIT:
  - Without ack: go to DISCARD.
  - With ack in the same cycle: the data is dropped and the state goes to IDLE.
- Redirect in IDLE, or in DISCARD without ack: takes the normal path. A repeated redirect in DISCARD only updates `fetch_pc`.
- DISCARD: hold `imem_req`=1 at the old address until ack. Drop the data, then go to IDLE.
- Simultaneous push and pop: both happen and `count` is unchanged; valid even when the FIFO is full.
- `fetch_pc` wraps modulo 2^ADDR_W.
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, `fifo_count`=0, state IDLE, `fetch_pc`=RESET_PC.
- Reset asserted mid-transaction: all state clears immediately. A late `imem_ack` arriving in IDLE is ignored.

## Timing
- `imem_req` rises on the first edge after `reset` deasserts.
- With a zero-wait memory (ack in the same cycle as req):
  - throughput is one instruction per cycle;
  - an ack captured at edge t makes `inst_valid` high from edge t onward.
- Outputs `inst`, `inst_pc` and `inst_valid` come from FIFO head registers or the head-indexed array. There is no combinational path from `imem_rdata` to them.
- Redirect to first new instruction:
  - from IDLE with a zero-wait memory, 2 cycles;
  - from DISCARD, add the residual memory latency.
- `fifo_count` reflects the post-edge occupancy.

## Structure
- Package `if_pkg` holds:
  - `if_state_t` enum {IDLE, WAIT, DISCARD};
  - `if_entry_t` struct {pc, inst};
  - constant `INST_NOP` = 32'h00000013 for bench filler.
- Sub-module `inst_fifo`: synchronous FIFO with DEPTH entries, parameterized on width and depth. Ports: push, pop, clear, count, head. The clear input has priority over push.
- `if_prefetch` holds the FSM, `fetch_pc` and the space check.

## Test plan
- Cold start, zero-wait memory, `stall`=0: `imem_addr` runs 0, 4, 8, 12; `inst_pc` follows one cycle after each ack; `inst_valid` stays high continuously.
- `stall` held high with DEPTH=4: exactly 4 pushes, then `imem_req`=0 and `fifo_count`=4. Releasing `stall` drains in order and refetches from 16.
- Memory with 3-cycle ack latency: `imem_addr` holds stable while `imem_req` is high; one instruction every 3 cycles.
- Redirect to 0x40 during WAIT with ack 2 cycles later: the old word is dropped, the FIFO is empty, the next request goes to 0x40, and the first `inst_pc` is 0x40.
- Redirect coinciding with both ack and pop on a full FIFO: no push, no pop, `fifo_count`=0 next cycle, next request at `redirect_pc`.
- Wrap-around: RESET_PC=0x1F8 with ADDR_W=9 produces fetches 0x1F8, 0x1FC, 0x000. Asserting `reset` mid-WAIT forces every output to its reset value within the same cycle.
